// File: rtl/full_subtractor_core_pkg.sv
// Shared datapath constants for the subtract/compare primitive.
// Other ALU blocks pick up the default operand width from here.
package full_subtractor_core_pkg;

  localparam int unsigned WIDTH_DEFAULT = 1;

endpackage

// File: rtl/full_subtractor_core_fs_cell.sv
// One-bit full subtractor cell: difference and borrow out.
// Purely combinational; chained by the top level into a ripple.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic Bor_in,
  output logic d,
  output logic Bor_out
);

  assign d       = a ^ b ^ Bor_in;
  assign Bor_out = (~a & b) | (~(a ^ b) & Bor_in);

endmodule

// File: rtl/full_subtractor_core.sv
// Registered ripple-borrow subtractor: a - b - Bor_in.
// One cycle of latency, synchronous clear, valid flag.
module full_subtractor_core
  import full_subtractor_core_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bor_in,
  output logic [WIDTH-1:0] d,
  output logic             Bor_out,
  output logic             out_valid
);

  logic [WIDTH:0]   br;
  logic [WIDTH-1:0] diff;

  assign br[0] = Bor_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fs_cell u_cell (
      .a      (a[i]),
      .b      (b[i]),
      .Bor_in (br[i]),
      .d      (diff[i]),
      .Bor_out(br[i+1])
    );
  end

  // Result holds when idle; only out_valid tracks in_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      d         <= '0;
      Bor_out   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        d       <= diff;
        Bor_out <= br[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor_core.sv
// Directed and randomized checks of full_subtractor_core
// at WIDTH = 1, 4 and 8.
module tb_full_subtractor_core;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bi;
    logic [3:0] d;
    logic       bo;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;

  logic       v1, v4, v8;
  logic       a1, b1, bi1, bi4, bi8;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       d1, bo1, ov1;
  logic [3:0] d4;
  logic       bo4, ov4;
  logic [7:0] d8;
  logic       bo8, ov8;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t t1[8];
  vec_t t4[3];

  always #5 clk = ~clk;

  full_subtractor_core #(.WIDTH(1)) u_w1 (
    .clk(clk), .reset(reset), .in_valid(v1),
    .a(a1), .b(b1), .Bor_in(bi1),
    .d(d1), .Bor_out(bo1), .out_valid(ov1)
  );

  full_subtractor_core #(.WIDTH(4)) u_w4 (
    .clk(clk), .reset(reset), .in_valid(v4),
    .a(a4), .b(b4), .Bor_in(bi4),
    .d(d4), .Bor_out(bo4), .out_valid(ov4)
  );

  full_subtractor_core #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(reset), .in_valid(v8),
    .a(a8), .b(b8), .Bor_in(bi8),
    .d(d8), .Bor_out(bo8), .out_valid(ov8)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    t1[0] = '{4'd0, 4'd0, 1'b0, 4'd0, 1'b0};
    t1[1] = '{4'd1, 4'd0, 1'b0, 4'd1, 1'b0};
    t1[2] = '{4'd0, 4'd1, 1'b0, 4'd1, 1'b1};
    t1[3] = '{4'd1, 4'd1, 1'b0, 4'd0, 1'b0};
    t1[4] = '{4'd0, 4'd0, 1'b1, 4'd1, 1'b1};
    t1[5] = '{4'd1, 4'd0, 1'b1, 4'd0, 1'b0};
    t1[6] = '{4'd0, 4'd1, 1'b1, 4'd0, 1'b1};
    t1[7] = '{4'd1, 4'd1, 1'b1, 4'd1, 1'b1};
    t4[0] = '{4'd3, 4'd5, 1'b0, 4'd14, 1'b1};
    t4[1] = '{4'd9, 4'd4, 1'b1, 4'd4,  1'b0};
    t4[2] = '{4'd0, 4'd0, 1'b1, 4'd15, 1'b1};

    reset = 1'b1;
    v1 = 0; v4 = 0; v8 = 0;
    a1 = 0; b1 = 0; bi1 = 0;
    a4 = 0; b4 = 0; bi4 = 0;
    a8 = 0; b8 = 0; bi8 = 0;
    tick();
    tick();
    check("rst_d1", d1, 0);
    check("rst_bo1", bo1, 0);
    check("rst_ov1", ov1, 0);
    check("rst_d4", d4, 0);
    check("rst_ov8", ov8, 0);
    reset = 1'b0;
    tick();
    check("idle_ov1", ov1, 0);

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      v1 = 1; a1 = t1[i].a[0]; b1 = t1[i].b[0]; bi1 = t1[i].bi;
      tick();
      check($sformatf("tt%0d_d", i), d1, t1[i].d);
      check($sformatf("tt%0d_bo", i), bo1, t1[i].bo);
      check($sformatf("tt%0d_ov", i), ov1, 1);
    end

    // reset priority over in_valid
    reset = 1; v1 = 1; a1 = 0; b1 = 1; bi1 = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rstp_d", d1, 0);
      check("rstp_bo", bo1, 0);
      check("rstp_ov", ov1, 0);
    end
    reset = 0;
    tick();
    check("post_rst_d", d1, 1);
    check("post_rst_bo", bo1, 1);
    check("post_rst_ov", ov1, 1);

    // hold while idle
    v1 = 0; a1 = 1;
    tick();
    check("hold_d", d1, 1);
    check("hold_bo", bo1, 1);
    check("hold_ov", ov1, 0);
    tick();
    check("hold2_d", d1, 1);
    check("hold2_ov", ov1, 0);

    // WIDTH=4 arithmetic
    for (int i = 0; i < 3; i++) begin
      v4 = 1; a4 = t4[i].a; b4 = t4[i].b; bi4 = t4[i].bi;
      tick();
      check($sformatf("w4_%0d_d", i), d4, t4[i].d);
      check($sformatf("w4_%0d_bo", i), bo4, t4[i].bo);
      check($sformatf("w4_%0d_ov", i), ov4, 1);
    end
    v4 = 0;

    // WIDTH=8 back-to-back random
    for (int i = 0; i < 1000; i++) begin
      int ea, eb, ebi;
      ea  = int'($urandom_range(255));
      eb  = int'($urandom_range(255));
      ebi = int'($urandom_range(1));
      v8 = 1; a8 = 8'(ea); b8 = 8'(eb); bi8 = 1'(ebi);
      tick();
      check("w8_d", d8, 32'((ea - eb - ebi) & 255));
      check("w8_bo", bo8, (ea < eb + ebi) ? 1 : 0);
      check("w8_ov", ov8, 1);
    end
    v8 = 0;
    tick();
    check("w8_end_ov", ov8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
